// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read address and read data channels for axi_rd_arbiter
// master: arbiter side driving AR and RREADY; slave: memory/bus side.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - N-port single-beat AXI4 read arbiter, responses routed back by RID
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module axi_rd_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid_i,
  output logic [N_PORTS-1:0]        req_ready_o,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [N_PORTS*3-1:0]      req_size_i,
  output logic [N_PORTS-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  output logic [N_PORTS-1:0]        busy_o,
  output logic                      stray_err_o,
  axi_rd_arbiter_if.master          axi
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic                 arvalid_q, arvalid_d;
  logic [ID_W-1:0]      arid_q, arid_d;
  logic [ADDR_W-1:0]    araddr_q, araddr_d;
  logic [2:0]           arsize_q, arsize_d;
  logic [N_PORTS-1:0]   busy_q, busy_d;
  logic [N_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 stray_q, stray_d;

  logic                 slot_free;
  logic [N_PORTS-1:0]   eligible;
  logic                 grant_any;
  logic [IDX_W-1:0]     win_idx;
  logic                 do_grant;
  logic [N_PORTS-1:0]   grant;
  logic [N_PORTS-1:0]   rid_hit;
  logic [N_PORTS-1:0]   done;
  logic                 r_ok;
  logic                 unused_rresp0;

  assign slot_free = ~arvalid_q | axi.arready;
  assign eligible  = req_valid_i & ~busy_q;

`ifdef AXI_RD_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic             any_hi;
  logic [IDX_W-1:0] hi_idx;

  // Prefer the lowest eligible index above the last winner, else wrap to the lowest overall.
  always_comb begin
    grant_any = 1'b0;
    win_idx   = '0;
    any_hi    = 1'b0;
    hi_idx    = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_any = 1'b1;
        win_idx   = IDX_W'(i);
        if (IDX_W'(i) > ptr_q) begin
          any_hi = 1'b1;
          hi_idx = IDX_W'(i);
        end
      end
    end
    if (any_hi) begin
      win_idx = hi_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(N_PORTS - 1);
    end else if (do_grant) begin
      ptr_q <= win_idx;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    win_idx   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_any = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`endif

  assign do_grant = ~rst & slot_free & grant_any;

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      grant[i] = do_grant && (win_idx == IDX_W'(i));
    end
  end

  assign req_ready_o = grant;

  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    if (do_grant) begin
      arvalid_d = 1'b1;
      arid_d    = ID_W'(win_idx);
    end else if (axi.arready) begin
      arvalid_d = 1'b0;
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        araddr_d = req_addr_i[i*ADDR_W +: ADDR_W];
        arsize_d = req_size_i[i*3 +: 3];
      end
    end
  end

  // RIDs outside the port range match nothing, so they fall through to the stray flag.
  always_comb begin
    rid_hit = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      rid_hit[i] = (axi.rid == ID_W'(i));
    end
  end

  assign r_ok = axi.rvalid & (|(rid_hit & busy_q));
  assign done = (axi.rvalid & axi.rlast) ? (rid_hit & busy_q) : '0;

  always_comb begin
    busy_d      = (busy_q & ~done) | grant;
    rsp_valid_d = done;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (|done) begin
      rsp_data_d = axi.rdata;
      rsp_err_d  = axi.rresp[1];
    end
    stray_d = stray_q | (axi.rvalid & ~r_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q   <= 1'b0;
      arid_q      <= '0;
      araddr_q    <= '0;
      arsize_q    <= '0;
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      arvalid_q   <= arvalid_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arsize_q    <= arsize_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      stray_q     <= stray_d;
    end
  end

  assign axi.arvalid  = arvalid_q;
  assign axi.arid     = arid_q;
  assign axi.araddr   = araddr_q;
  assign axi.arsize   = arsize_q;
  assign axi.arlen    = 8'd0;
  assign axi.arburst  = 2'b01;
  assign axi.arlock   = 1'b0;
  assign axi.arcache  = 4'd0;
  assign axi.arprot   = 3'd0;
  assign axi.arqos    = 4'd0;
  assign axi.arregion = 4'd0;
  assign axi.rready   = ~rst;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  assign stray_err_o  = stray_q;

  assign unused_rresp0 = axi.rresp[0];
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
// Directed vector table, hand sequences, then random traffic against a rule-level model.
module tb_axi_rd_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*3-1:0]  req_size = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic [N-1:0]    busy;
  logic            stray_err;

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) axi ();

  axi_rd_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_size_i  (req_size),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .stray_err_o (stray_err),
    .axi         (axi)
  );

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] m_addr [N];
  logic [2:0]    m_size [N];

  typedef struct packed {
    logic [1:0]  rv;
    logic        ardy;
    logic        rvl;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic [1:0]  e_rdy;
    logic        e_arv;
    logic [3:0]  e_arid;
    logic [1:0]  e_busy;
    logic [1:0]  e_rsp;
    logic [31:0] e_data;
    logic        e_err;
    logic        e_stray;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
  task automatic drive(input logic r, input logic [N-1:0] rv, input logic ardy, input logic rvl,
                       input logic [IW-1:0] rid, input logic [1:0] rresp, input logic [DW-1:0] rdata);
    @(posedge clk);
    #1;
    rst = r;
    for (int p = 0; p < N; p++) begin
      req_addr[p*AW +: AW] = m_addr[p];
      req_size[p*3 +: 3]   = m_size[p];
    end
    req_valid   = rv;
    axi.arready = ardy;
    axi.rvalid  = rvl;
    axi.rid     = rid;
    axi.rresp   = rresp;
    axi.rdata   = rdata;
    axi.rlast   = 1'b1;
    #4;
  endtask

  bit            m_busy [N];
  bit            hold [N];
  bit            m_arv;
  int            m_arport;
  logic [AW-1:0] m_araddr;
  logic [2:0]    m_arsize;
  logic [N-1:0]  m_rsp;
  logic [DW-1:0] m_rdata;
  logic          m_rerr;
  logic          m_stray;
  int            outq [$];
`ifdef AXI_RD_ARB_RR_EN
  int            rr_last;
`endif

  initial begin
    logic [N-1:0]  rv;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_busy;
    logic          ardy;
    logic          rvl;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic [DW-1:0] rdata;
    int            k;
    int            win;
    int            c;
    bit            slot_free;

    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rid     = '0;
    axi.rresp   = '0;
    axi.rdata   = '0;
    axi.rlast   = 1'b0;
    m_addr[0] = 64'h8000_0000; m_size[0] = 3'd2;
    m_addr[1] = 64'h0000_1000; m_size[1] = 3'd3;

    //        rv    ardy  rvl   rid   rresp rdata         e_rdy e_arv earid ebusy ersp  edata         eerr  estray
    tv[0]  = '{2'b01, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b01, 1'b0, 4'd0, 2'b00, 2'b00, 32'h0,        1'b0, 1'b0};
    tv[1]  = '{2'b00, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b00, 1'b1, 4'd0, 2'b01, 2'b00, 32'h0,        1'b0, 1'b0};
    tv[2]  = '{2'b00, 1'b1, 1'b1, 4'd0, 2'd0, 32'hDEADBEEF, 2'b00, 1'b0, 4'd0, 2'b01, 2'b00, 32'h0,        1'b0, 1'b0};
    tv[3]  = '{2'b00, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b00, 1'b0, 4'd0, 2'b00, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[4]  = '{2'b01, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b01, 1'b0, 4'd0, 2'b00, 2'b00, 32'h0,        1'b0, 1'b0};
    tv[5]  = '{2'b10, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b10, 1'b1, 4'd0, 2'b01, 2'b00, 32'h0,        1'b0, 1'b0};
    tv[6]  = '{2'b00, 1'b1, 1'b1, 4'd1, 2'd2, 32'h1111,     2'b00, 1'b1, 4'd1, 2'b11, 2'b00, 32'h0,        1'b0, 1'b0};
    tv[7]  = '{2'b00, 1'b1, 1'b1, 4'd0, 2'd0, 32'h2222,     2'b00, 1'b0, 4'd0, 2'b01, 2'b10, 32'h1111,     1'b1, 1'b0};
    tv[8]  = '{2'b00, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b00, 1'b0, 4'd0, 2'b00, 2'b01, 32'h2222,     1'b0, 1'b0};
    tv[9]  = '{2'b00, 1'b1, 1'b1, 4'd5, 2'd0, 32'h5555,     2'b00, 1'b0, 4'd0, 2'b00, 2'b00, 32'h0,        1'b0, 1'b0};
    tv[10] = '{2'b00, 1'b1, 1'b1, 4'd0, 2'd0, 32'h6666,     2'b00, 1'b0, 4'd0, 2'b00, 2'b00, 32'h0,        1'b0, 1'b1};
    tv[11] = '{2'b00, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b00, 1'b0, 4'd0, 2'b00, 2'b00, 32'h0,        1'b0, 1'b1};
    tv[12] = '{2'b01, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b01, 1'b0, 4'd0, 2'b00, 2'b00, 32'h0,        1'b0, 1'b1};
    tv[13] = '{2'b01, 1'b1, 1'b1, 4'd0, 2'd0, 32'h3333,     2'b00, 1'b1, 4'd0, 2'b01, 2'b00, 32'h0,        1'b0, 1'b1};
    tv[14] = '{2'b01, 1'b1, 1'b0, 4'd0, 2'd0, 32'h0,        2'b01, 1'b0, 4'd0, 2'b00, 2'b01, 32'h3333,     1'b0, 1'b1};
    tv[15] = '{2'b00, 1'b0, 1'b0, 4'd0, 2'd0, 32'h0,        2'b00, 1'b1, 4'd0, 2'b01, 2'b00, 32'h0,        1'b0, 1'b1};

    drive(1'b1, 2'b11, 1'b1, 1'b0, '0, '0, '0);
    chk("rst req_ready", req_ready, 0);
    chk("rst rready", axi.rready, 0);
    chk("rst arvalid", axi.arvalid, 0);
    chk("rst arid", axi.arid, 0);
    chk("rst araddr", axi.araddr, 0);
    chk("rst arsize", axi.arsize, 0);
    chk("rst busy", busy, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst stray", stray_err, 0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, tv[i].rv, tv[i].ardy, tv[i].rvl, tv[i].rid, tv[i].rresp, {32'h0, tv[i].rdata});
      chk($sformatf("v%0d req_ready", i), req_ready, tv[i].e_rdy);
      chk($sformatf("v%0d arvalid", i), axi.arvalid, tv[i].e_arv);
      chk($sformatf("v%0d busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, tv[i].e_rsp);
      chk($sformatf("v%0d stray", i), stray_err, tv[i].e_stray);
      chk($sformatf("v%0d rready", i), axi.rready, 1);
      if (tv[i].e_arv) begin
        chk($sformatf("v%0d arid", i), axi.arid, tv[i].e_arid);
        chk($sformatf("v%0d araddr", i), axi.araddr, m_addr[tv[i].e_arid[0]]);
        chk($sformatf("v%0d arsize", i), axi.arsize, m_size[tv[i].e_arid[0]]);
        chk($sformatf("v%0d arlen", i), axi.arlen, 0);
        chk($sformatf("v%0d arburst", i), axi.arburst, 1);
      end
      if (tv[i].e_rsp != 2'b00) begin
        chk($sformatf("v%0d rsp_data", i), rsp_data, {32'h0, tv[i].e_data});
        chk($sformatf("v%0d rsp_err", i), rsp_err, tv[i].e_err);
      end
    end

    // Reset with both ports outstanding and the AR slot occupied.
    drive(1'b0, 2'b10, 1'b1, 1'b0, '0, '0, '0);
    chk("mid grant1", req_ready, 2'b10);
    drive(1'b0, 2'b00, 1'b0, 1'b0, '0, '0, '0);
    chk("mid arvalid", axi.arvalid, 1);
    chk("mid arid", axi.arid, 1);
    chk("mid busy", busy, 2'b11);
    chk("mid stray", stray_err, 1);
    drive(1'b1, 2'b11, 1'b0, 1'b0, '0, '0, '0);
    chk("in rst req_ready", req_ready, 0);
    chk("in rst rready", axi.rready, 0);
    drive(1'b0, 2'b01, 1'b1, 1'b0, '0, '0, '0);
    chk("post rst arvalid", axi.arvalid, 0);
    chk("post rst busy", busy, 0);
    chk("post rst stray", stray_err, 0);
    chk("post rst req_ready", req_ready, 2'b01);
    drive(1'b0, 2'b00, 1'b1, 1'b0, '0, '0, '0);
    chk("post rst arid", axi.arid, 0);
    chk("post rst araddr", axi.araddr, 64'h8000_0000);

    // ARREADY low for five cycles while port 1 holds the slot.
    drive(1'b0, 2'b10, 1'b0, 1'b0, '0, '0, '0);
    chk("hold grant1", req_ready, 2'b10);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b11, 1'b0, 1'b0, '0, '0, '0);
      chk($sformatf("hold%0d req_ready", i), req_ready, 2'b00);
      chk($sformatf("hold%0d arvalid", i), axi.arvalid, 1);
      chk($sformatf("hold%0d arid", i), axi.arid, 1);
      chk($sformatf("hold%0d araddr", i), axi.araddr, 64'h1000);
      chk($sformatf("hold%0d arsize", i), axi.arsize, 3);
    end
    drive(1'b0, 2'b00, 1'b1, 1'b0, '0, '0, '0);
    chk("hold release arvalid", axi.arvalid, 1);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 4'd1, 2'd0, 64'hAAAA);
    chk("ooo busy", busy, 2'b11);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 2'd0, 64'hBBBB);
    chk("ooo rsp1", rsp_valid, 2'b10);
    chk("ooo data1", rsp_data, 64'hAAAA);
    drive(1'b0, 2'b00, 1'b0, 1'b0, '0, '0, '0);
    chk("ooo rsp0", rsp_valid, 2'b01);
    chk("ooo data0", rsp_data, 64'hBBBB);
    chk("ooo busy clear", busy, 2'b00);

    // Random traffic against the model.
    m_arv = 1'b0; m_rsp = '0; m_stray = 1'b0; m_rdata = '0; m_rerr = 1'b0;
    m_arport = 0; m_araddr = '0; m_arsize = '0;
    for (int p = 0; p < N; p++) begin
      m_busy[p] = 1'b0;
      hold[p]   = 1'b0;
    end
`ifdef AXI_RD_ARB_RR_EN
    rr_last = 1;
`endif
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (!hold[p] && $urandom_range(0, 2) == 0) begin
          hold[p]   = 1'b1;
          m_addr[p] = {$urandom, $urandom};
          m_size[p] = 3'($urandom_range(0, 3));
        end
        rv[p] = hold[p];
      end
      ardy  = ($urandom_range(0, 3) != 0);
      rvl   = 1'b0;
      rid   = '0;
      rresp = 2'($urandom_range(0, 3));
      rdata = {$urandom, $urandom};
      if (outq.size() > 0 && $urandom_range(0, 1) == 1) begin
        k   = $urandom_range(0, outq.size() - 1);
        rvl = 1'b1;
        rid = IW'(outq[k]);
      end else if ($urandom_range(0, 24) == 0) begin
        rvl = 1'b1;
        rid = IW'($urandom_range(0, 15));
      end
      drive(1'b0, rv, ardy, rvl, rid, rresp, rdata);

      slot_free = !m_arv || ardy;
      win = -1;
      if (slot_free) begin
        for (int s = 0; s < N; s++) begin
`ifdef AXI_RD_ARB_RR_EN
          c = (rr_last + 1 + s) % N;
`else
          c = s;
`endif
          if (win < 0 && rv[c] && !m_busy[c]) win = c;
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      for (int p = 0; p < N; p++) exp_busy[p] = m_busy[p];

      chk("rnd req_ready", req_ready, exp_rdy);
      chk("rnd arvalid", axi.arvalid, m_arv);
      if (m_arv) begin
        chk("rnd arid", axi.arid, m_arport);
        chk("rnd araddr", axi.araddr, m_araddr);
        chk("rnd arsize", axi.arsize, m_arsize);
      end
      chk("rnd busy", busy, exp_busy);
      chk("rnd rsp_valid", rsp_valid, m_rsp);
      if (m_rsp != '0) begin
        chk("rnd rsp_data", rsp_data, m_rdata);
        chk("rnd rsp_err", rsp_err, m_rerr);
      end
      chk("rnd stray", stray_err, m_stray);

      if (m_arv && ardy) begin
        outq.push_back(m_arport);
        m_arv = 1'b0;
      end
      m_rsp = '0;
      if (rvl) begin
        if (rid < N && m_busy[rid]) begin
          m_rsp[rid]  = 1'b1;
          m_rdata     = rdata;
          m_rerr      = rresp[1];
          m_busy[rid] = 1'b0;
          for (int j = 0; j < outq.size(); j++) begin
            if (outq[j] == int'(rid)) begin
              outq.delete(j);
              break;
            end
          end
        end else begin
          m_stray = 1'b1;
        end
      end
      if (win >= 0) begin
        m_arv       = 1'b1;
        m_arport    = win;
        m_araddr    = m_addr[win];
        m_arsize    = m_size[win];
        m_busy[win] = 1'b1;
        hold[win]   = 1'b0;
`ifdef AXI_RD_ARB_RR_EN
        rr_last     = win;
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
